// File: rtl/alu_seq_param.sv
// Registered ALU with valid/ready handshake: single-cycle logic/arith/shift ops
// plus iterative unsigned shift-add multiply and restoring divide.
module alu_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] H,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;

  // EXEC is the single cycle between operand latch (or last iteration) and result write
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_h;
  logic             r_zero;
  logic             r_ovf;
  logic             r_outValid;
  logic             r_busy;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divRem;
  logic [WIDTH-1:0] w_divDiff;
  logic             w_divGe;
  logic [WIDTH-1:0] w_resC;
  logic [WIDTH-1:0] w_resH;
  logic             w_resOvf;

  assign w_shamt   = r_b[SHW-1:0];
  assign w_add     = r_a + r_b;
  assign w_sub     = r_a - r_b;
  assign w_sra     = WIDTH'($signed(r_a) >>> w_shamt);
  assign w_mulSum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  // Partial remainder is below the divisor, so a successful subtract fits in WIDTH bits
  assign w_divRem  = {r_hi, r_lo[WIDTH-1]};
  assign w_divGe   = (w_divRem >= {1'b0, r_b});
  assign w_divDiff = w_divRem[WIDTH-1:0] - r_b;

  always_comb begin
    w_resC   = '0;
    w_resH   = '0;
    w_resOvf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_resC   = w_add;
        w_resOvf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_resC   = w_sub;
        w_resOvf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_resC = r_a & r_b;
      OP_OR:  w_resC = r_a | r_b;
      OP_SRL: w_resC = r_a >> w_shamt;
      OP_SRA: w_resC = w_sra;
      default: begin
        w_resC = r_lo;
        w_resH = r_hi;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_c        <= '0;
      r_h        <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_op  <= ALUOp;
            r_cnt <= '0;
            if (ALUOp[2:1] == 2'b11) begin
              r_hi    <= '0;
              r_lo    <= ALUOp[0] ? A : B;
              r_busy  <= 1'b1;
              r_state <= S_BUSY;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_BUSY: begin
          if (!r_op[0]) begin
            r_hi <= w_mulSum[WIDTH:1];
            r_lo <= {w_mulSum[0], r_lo[WIDTH-1:1]};
          end else if (w_divGe) begin
            r_hi <= w_divDiff;
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_divRem[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == (SHW+1)'(WIDTH-1)) begin
            r_busy  <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_c        <= w_resC;
          r_h        <= w_resH;
          r_zero     <= (w_resC == '0);
          r_ovf      <= w_resOvf;
          r_outValid <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_outValid;
  assign C         = r_c;
  assign H         = r_h;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule
